// File: rtl/span_pixel_writer.sv
// Horizontal span to pixel-write converter.
// Orders and clips span endpoints, then streams one framebuffer write per cycle.
module span_pixel_writer #(
   parameter int COORD_W  = 16,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int ADDR_W   = 19,
   parameter int COLOR_W  = 12
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               span_valid,
   output logic               span_ready,
   input  logic [COORD_W-1:0] span_y,
   input  logic [COORD_W-1:0] span_x0,
   input  logic [COORD_W-1:0] span_x1,
   input  logic [COLOR_W-1:0] span_color,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic [ADDR_W-1:0]  pix_addr,
   output logic [COLOR_W-1:0] pix_color,
   output logic               pix_last,
   output logic               span_dropped
);

   typedef enum logic {IDLE, FILL} state_t;

   localparam logic signed [COORD_W-1:0] LP_XMAX = COORD_W'(SCREEN_W - 1);
   localparam logic signed [COORD_W-1:0] LP_YLIM = COORD_W'(SCREEN_H);
   localparam logic [ADDR_W-1:0]         LP_W    = ADDR_W'(SCREEN_W);

   state_t r_state;
   state_t w_next;

   logic                      r_live;
   logic signed [COORD_W-1:0] r_x;
   logic signed [COORD_W-1:0] r_y;
   logic signed [COORD_W-1:0] r_xr;
   logic [ADDR_W-1:0]         r_addr;
   logic [COLOR_W-1:0]        r_color;
   logic                      r_dropped;

   logic signed [COORD_W-1:0] w_x0;
   logic signed [COORD_W-1:0] w_x1;
   logic signed [COORD_W-1:0] w_y;
   logic signed [COORD_W-1:0] w_lo;
   logic signed [COORD_W-1:0] w_hi;
   logic signed [COORD_W-1:0] w_xl;
   logic signed [COORD_W-1:0] w_xr;
   logic [ADDR_W-1:0]         w_base;
   logic                      w_drop;
   logic                      w_accept;
   logic                      w_fire;
   logic                      w_last;

   assign w_x0 = $signed(span_x0);
   assign w_x1 = $signed(span_x1);
   assign w_y  = $signed(span_y);

   assign w_lo = (w_x0 < w_x1) ? w_x0 : w_x1;
   assign w_hi = (w_x0 < w_x1) ? w_x1 : w_x0;
   assign w_xl = w_lo[COORD_W-1] ? '0 : w_lo;
   assign w_xr = (w_hi > LP_XMAX) ? LP_XMAX : w_hi;

   assign w_drop = w_y[COORD_W-1] || (w_y >= LP_YLIM) || (w_xl > w_xr);
   // only evaluated for in-range y, so the row base never overflows
   assign w_base = ADDR_W'($unsigned(w_y)) * LP_W;

   assign span_ready = r_live && (r_state == IDLE);
   assign pix_valid  = (r_state == FILL);
   assign w_last     = pix_valid && (r_x == r_xr);
   assign pix_last   = w_last;
   assign w_accept   = span_valid && span_ready;
   assign w_fire     = pix_valid && pix_ready;

   assign pix_x        = r_x;
   assign pix_y        = r_y;
   assign pix_addr     = r_addr;
   assign pix_color    = r_color;
   assign span_dropped = r_dropped;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (w_accept && !w_drop) w_next = FILL;
         FILL: if (w_fire && w_last)    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live    <= 1'b0;
         r_x       <= '0;
         r_y       <= '0;
         r_xr      <= '0;
         r_addr    <= '0;
         r_color   <= '0;
         r_dropped <= 1'b0;
      end else begin
         r_live    <= 1'b1;
         r_dropped <= w_accept && w_drop;
         if (w_accept && !w_drop) begin
            r_x     <= w_xl;
            r_y     <= w_y;
            r_xr    <= w_xr;
            r_addr  <= w_base + ADDR_W'($unsigned(w_xl));
            r_color <= span_color;
         end else if (w_fire && !w_last) begin
            r_x    <= r_x + 1'b1;
            r_addr <= r_addr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_span_pixel_writer.sv
// Directed self-checking bench for span_pixel_writer.
// Each task drives one scenario and compares against hand-computed values.
module tb_span_pixel_writer;

   logic        clk;
   logic        rst_n;
   logic        span_valid;
   logic        span_ready;
   logic [15:0] span_y;
   logic [15:0] span_x0;
   logic [15:0] span_x1;
   logic [11:0] span_color;
   logic        pix_valid;
   logic        pix_ready;
   logic [15:0] pix_x;
   logic [15:0] pix_y;
   logic [18:0] pix_addr;
   logic [11:0] pix_color;
   logic        pix_last;
   logic        span_dropped;

   int n_checks = 0;
   int n_errors = 0;

   span_pixel_writer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .span_valid   (span_valid),
      .span_ready   (span_ready),
      .span_y       (span_y),
      .span_x0      (span_x0),
      .span_x1      (span_x1),
      .span_color   (span_color),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .pix_addr     (pix_addr),
      .pix_color    (pix_color),
      .pix_last     (pix_last),
      .span_dropped (span_dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offer a span for one edge; returns #1 after the accepting edge.
   task automatic send(input int y, input int x0, input int x1,
                       input logic [11:0] c);
      span_y     = 16'(y);
      span_x0    = 16'(x0);
      span_x1    = 16'(x1);
      span_color = c;
      span_valid = 1'b1;
      @(posedge clk); #1;
      span_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (span_ready !== 1'b0 || pix_valid !== 1'b0 || span_dropped !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: ready=%b valid=%b drop=%b want 0 0 0",
                  span_ready, pix_valid, span_dropped);
      end
      n_checks++;
      if (pix_x !== 16'd0 || pix_y !== 16'd0 || pix_addr !== 19'd0 ||
          pix_color !== 12'd0 || pix_last !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_data: x=%0d y=%0d addr=%0d c=%h last=%b want zeros",
                  pix_x, pix_y, pix_addr, pix_color, pix_last);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (span_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release: span_ready=%b want 1", span_ready);
      end
   endtask

   task automatic test_basic();
      send(10, 5, 8, 12'hABC);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (pix_valid !== 1'b1 || pix_x !== 16'(5 + i) ||
             pix_addr !== 19'(6405 + i) || pix_last !== (i == 3) ||
             pix_y !== 16'd10 || pix_color !== 12'hABC || span_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL basic[%0d]: v=%b x=%0d a=%0d l=%b y=%0d c=%h r=%b want 1 %0d %0d %b 10 abc 0",
                     i, pix_valid, pix_x, pix_addr, pix_last, pix_y, pix_color,
                     span_ready, 5 + i, 6405 + i, i == 3);
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (pix_valid !== 1'b0 || span_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL basic_end: valid=%b ready=%b want 0 1", pix_valid, span_ready);
      end
   endtask

   task automatic test_reversed();
      send(2, 20, 17, 12'h123);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (pix_valid !== 1'b1 || pix_x !== 16'(17 + i) ||
             pix_addr !== 19'(1297 + i) || pix_last !== (i == 3)) begin
            n_errors++;
            $display("FAIL reversed[%0d]: v=%b x=%0d a=%0d l=%b want 1 %0d %0d %b",
                     i, pix_valid, pix_x, pix_addr, pix_last, 17 + i, 1297 + i, i == 3);
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (pix_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL reversed_end: valid=%b want 0", pix_valid);
      end
   endtask

   task automatic test_clip();
      send(0, -3, 2, 12'h00F);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (pix_valid !== 1'b1 || pix_x !== 16'(i) ||
             pix_addr !== 19'(i) || pix_last !== (i == 2)) begin
            n_errors++;
            $display("FAIL clip_left[%0d]: v=%b x=%0d a=%0d l=%b want 1 %0d %0d %b",
                     i, pix_valid, pix_x, pix_addr, pix_last, i, i, i == 2);
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (pix_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL clip_left_end: valid=%b want 0", pix_valid);
      end
      send(479, 630, 700, 12'hF00);
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (pix_valid !== 1'b1 || pix_x !== 16'(630 + i) ||
             pix_addr !== 19'(307190 + i) || pix_last !== (i == 9)) begin
            n_errors++;
            $display("FAIL clip_right[%0d]: v=%b x=%0d a=%0d l=%b want 1 %0d %0d %b",
                     i, pix_valid, pix_x, pix_addr, pix_last, 630 + i, 307190 + i, i == 9);
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (pix_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL clip_right_end: valid=%b want 0", pix_valid);
      end
   endtask

   task automatic test_drop();
      for (int k = 0; k < 2; k++) begin
         if (k == 0) send(480, 5, 8, 12'h111);
         else        send(10, -5, -5, 12'h222);
         n_checks++;
         if (span_dropped !== 1'b1 || pix_valid !== 1'b0 || span_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL drop%0d_pulse: drop=%b valid=%b ready=%b want 1 0 1",
                     k, span_dropped, pix_valid, span_ready);
         end
         @(posedge clk); #1;
         n_checks++;
         if (span_dropped !== 1'b0 || pix_valid !== 1'b0 || span_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL drop%0d_after: drop=%b valid=%b ready=%b want 0 0 1",
                     k, span_dropped, pix_valid, span_ready);
         end
      end
   endtask

   task automatic test_stall();
      send(10, 5, 8, 12'h5A5);
      n_checks++;
      if (pix_x !== 16'd5 || pix_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL stall_first: x=%0d valid=%b want 5 1", pix_x, pix_valid);
      end
      @(posedge clk); #1;
      pix_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (pix_valid !== 1'b1 || pix_x !== 16'd6 || pix_addr !== 19'd6406 ||
             pix_last !== 1'b0 || pix_color !== 12'h5A5) begin
            n_errors++;
            $display("FAIL stall_hold[%0d]: v=%b x=%0d a=%0d l=%b c=%h want 1 6 6406 0 5a5",
                     i, pix_valid, pix_x, pix_addr, pix_last, pix_color);
         end
      end
      pix_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (pix_valid !== 1'b1 || pix_x !== 16'(6 + i) ||
             pix_addr !== 19'(6406 + i) || pix_last !== (i == 2)) begin
            n_errors++;
            $display("FAIL stall_seq[%0d]: v=%b x=%0d a=%0d l=%b want 1 %0d %0d %b",
                     i, pix_valid, pix_x, pix_addr, pix_last, 6 + i, 6406 + i, i == 2);
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (pix_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL stall_end: valid=%b want 0", pix_valid);
      end
   endtask

   task automatic test_ignore_in_fill();
      send(3, 0, 1, 12'h777);
      span_y     = 16'd5;
      span_x0    = 16'd7;
      span_x1    = 16'd7;
      span_valid = 1'b1;
      n_checks++;
      if (pix_x !== 16'd0 || pix_addr !== 19'd1920 || pix_last !== 1'b0) begin
         n_errors++;
         $display("FAIL ignore_p0: x=%0d a=%0d l=%b want 0 1920 0", pix_x, pix_addr, pix_last);
      end
      @(posedge clk); #1;
      span_valid = 1'b0;
      n_checks++;
      if (pix_x !== 16'd1 || pix_y !== 16'd3 || pix_addr !== 19'd1921 || pix_last !== 1'b1) begin
         n_errors++;
         $display("FAIL ignore_p1: x=%0d y=%0d a=%0d l=%b want 1 3 1921 1",
                  pix_x, pix_y, pix_addr, pix_last);
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (pix_valid !== 1'b0 || span_dropped !== 1'b0) begin
         n_errors++;
         $display("FAIL ignore_end: valid=%b drop=%b want 0 0", pix_valid, span_dropped);
      end
   endtask

   task automatic test_back_to_back();
      send(1, 3, 3, 12'h0F0);
      n_checks++;
      if (pix_valid !== 1'b1 || pix_x !== 16'd3 || pix_addr !== 19'd643 || pix_last !== 1'b1) begin
         n_errors++;
         $display("FAIL single: v=%b x=%0d a=%0d l=%b want 1 3 643 1",
                  pix_valid, pix_x, pix_addr, pix_last);
      end
      @(posedge clk); #1;
      n_checks++;
      if (pix_valid !== 1'b0 || span_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL bubble: valid=%b ready=%b want 0 1", pix_valid, span_ready);
      end
      send(479, 639, 639, 12'hFFF);
      n_checks++;
      if (pix_valid !== 1'b1 || pix_x !== 16'd639 || pix_addr !== 19'd307199 || pix_last !== 1'b1) begin
         n_errors++;
         $display("FAIL corner: v=%b x=%0d a=%0d l=%b want 1 639 307199 1",
                  pix_valid, pix_x, pix_addr, pix_last);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_in_fill();
      send(10, 5, 8, 12'hABC);
      @(posedge clk); #1;
      n_checks++;
      if (pix_x !== 16'd6 || pix_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL rfill_pre: x=%0d valid=%b want 6 1", pix_x, pix_valid);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (pix_valid !== 1'b0 || span_ready !== 1'b0 || pix_x !== 16'd0 || pix_last !== 1'b0) begin
         n_errors++;
         $display("FAIL rfill_async: valid=%b ready=%b x=%0d last=%b want 0 0 0 0",
                  pix_valid, span_ready, pix_x, pix_last);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (span_ready !== 1'b1 || pix_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL rfill_release: ready=%b valid=%b want 1 0", span_ready, pix_valid);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (pix_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL rfill_abandon: valid=%b want 0", pix_valid);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      span_valid = 1'b0;
      span_y     = '0;
      span_x0    = '0;
      span_x1    = '0;
      span_color = '0;
      pix_ready  = 1'b1;
      #1;
      test_reset();
      test_basic();
      test_reversed();
      test_clip();
      test_drop();
      test_stall();
      test_ignore_in_fill();
      test_back_to_back();
      test_reset_in_fill();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/span_pixel_writer.md
SPAN_PIXEL_WRITER -- requirements
Module: span_pixel_writer

Interface
REQ-001 The block SHALL provide parameter COORD_W, default 16, signed coordinate width in integer pixels.
REQ-002 The block SHALL provide parameter SCREEN_W, default 640, framebuffer width in pixels.
REQ-003 The block SHALL provide parameter SCREEN_H, default 480, framebuffer height in pixels.
REQ-004 The block SHALL provide parameter ADDR_W, default 19, framebuffer address width.
REQ-005 The block SHALL provide parameter COLOR_W, default 12, pixel color width.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 The block SHALL provide port: clk  input  1  sole clock, rising edge.
REQ-008 The block SHALL provide port: rst_n  input  1  asynchronous active-low reset.
REQ-009 The block SHALL provide port: span_valid  input  1  span offered by the rasterizer.
REQ-010 The block SHALL provide port: span_ready  output  1  block accepts a span this cycle.
REQ-011 The block SHALL provide port: span_y  input  COORD_W  scanline, signed.
REQ-012 The block SHALL provide port: span_x0 / span_x1  input  COORD_W each  span endpoints, signed, any order.
REQ-013 The block SHALL provide port: span_color  input  COLOR_W  fill color.
REQ-014 The block SHALL provide port: pix_valid  output  1  pixel write offered.
REQ-015 The block SHALL provide port: pix_ready  input  1  framebuffer accepts the pixel.
REQ-016 The block SHALL provide port: pix_x / pix_y  output  COORD_W each  pixel coordinate.
REQ-017 The block SHALL provide port: pix_addr  output  ADDR_W  linear address y*SCREEN_W+x.
REQ-018 The block SHALL provide port: pix_color  output  COLOR_W  pixel color.
REQ-019 The block SHALL provide port: pix_last  output  1  final pixel of the span.
REQ-020 The block SHALL provide port: span_dropped  output  1  one-cycle pulse when an accepted span yields no pixels.

Function
REQ-021 The block SHALL implement an FSM with two states: IDLE and FILL.
REQ-022 In IDLE the block SHALL drive span_ready=1; in FILL it SHALL drive span_ready=0.
REQ-023 A span SHALL be accepted on a rising edge where span_valid and span_ready are both 1.
REQ-024 On acceptance the block SHALL order the endpoints as xl=min(x0,x1) and xr=max(x0,x1), using signed comparison.
REQ-025 The block SHALL clip as xl=max(xl,0) and xr=min(xr,SCREEN_W-1).
REQ-026 If span_y<0, span_y>=SCREEN_H, or clipped xl>xr, the block SHALL stay in IDLE, emit no pixels, and pulse span_dropped for exactly the next cycle.
REQ-027 Otherwise the block SHALL latch y, xl, xr, color and row base y*SCREEN_W, then enter FILL.
REQ-028 pix_valid SHALL rise the cycle after acceptance (latency 1), presenting x=xl and pix_addr=base+xl.
REQ-029 On each pix_valid&&pix_ready edge, x and pix_addr SHALL each increment by 1.
REQ-030 pix_last SHALL equal 1 exactly when pix_valid=1 and x==xr.
REQ-031 A handshake on the pixel with pix_last=1 SHALL return the FSM to IDLE with pix_valid=0; span_ready SHALL be 1 in the following cycle (one-cycle bubble between spans).
REQ-032 While pix_valid=1 and pix_ready=0, all pix_* outputs SHALL hold stable; no pixel SHALL be skipped or duplicated.
REQ-033 Span inputs SHALL be ignored in FILL.
REQ-034 A single-pixel span (xl==xr) SHALL produce one pixel with pix_last=1.
REQ-035 The maximum span SHALL be SCREEN_W pixels; address arithmetic SHALL NOT overflow ADDR_W for in-range pixels.

Reset
REQ-036 While rst_n=0 the block SHALL force IDLE state, span_ready=0, and zero on pix_valid, pix_x, pix_y, pix_addr, pix_color, pix_last and span_dropped, independent of clk.
REQ-037 The block SHALL drive span_ready=1 from the first clock edge after rst_n deasserts.
REQ-038 A reset during FILL SHALL abandon the span, and no remaining pixels SHALL be emitted.

Verification
REQ-039 The bench SHALL apply y=10, x0=5, x1=8 with pix_ready=1 and SHALL check x=5..8 on 4 consecutive cycles starting 1 cycle after acceptance, addr 6405..6408, and pix_last only at x=8.
REQ-040 The bench SHALL apply y=2, x0=20, x1=17 and SHALL check x=17..20 and addr 1297..1300.
REQ-041 The bench SHALL apply y=0, x0=-3, x1=2 and SHALL check x=0..2 and addr 0..2; it SHALL then apply y=479, x0=630, x1=700 and SHALL check x=630..639 and addr 307190..307199.
REQ-042 The bench SHALL apply y=480 and, separately, x0=x1=-5 and SHALL check no pix_valid, a span_dropped pulse of 1 cycle, and span_ready remaining 1.
REQ-043 The bench SHALL hold pix_ready=0 for 3 cycles at x=6 of the REQ-039 span and SHALL check that the outputs hold and the sequence is 5,6,7,8 exactly.
REQ-044 The bench SHALL assert rst_n=0 at x=6 and SHALL check that pix_valid=0 immediately and that span_ready=1 on the first edge after release.
